// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: controller states, op-select encoding and defaults.
package fpu_pkg;

  // Issue controller states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fpu_state_t;

  // Bit of the decoded control word that marks an FPU operation
  localparam int FPU_OP_BIT = 4;

  // Default width of the latency counter and of the decoded latency field
  localparam int LAT_W_DEFAULT = 4;

  // 5-bit FPU op codes presented on fpu_cont / fpu_sel
  localparam logic [4:0] OP_FADD   = 5'b10000;
  localparam logic [4:0] OP_FSUB   = 5'b10001;
  localparam logic [4:0] OP_FMUL   = 5'b10010;
  localparam logic [4:0] OP_FDIV   = 5'b10011;
  localparam logic [4:0] OP_FSQRT  = 5'b10100;
  localparam logic [4:0] OP_FSGNJ  = 5'b11000;
  localparam logic [4:0] OP_FCVTSW = 5'b11100;

endpackage

// File: rtl/fpu_issue_ctrl_lat_counter.sv
// Loadable down-counter that times a multi-cycle FPU operation.
// last flags the final cycle of the operation (cnt == 1).
module fpu_lat_counter #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == LAT_W'(1));

  // Load on accept, count down while waiting, clear on a pipeline kill
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts FPU ops from execute, stalls the pipeline for
// the decoded latency, then captures the FPU result for a one-cycle writeback.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT_W  = LAT_W_DEFAULT,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue_valid,
  input  logic [4:0]        fpu_cont,
  input  logic [LAT_W-1:0]  fpu_stall,
  input  logic [4:0]        rd_addr,
  input  logic              rd_reg_src,
  input  logic              regwrite_in,
  input  logic              flush,
  input  logic [DATA_W-1:0] fpu_y,
  output logic [4:0]        fpu_sel,
  output logic              stall,
  output logic              busy,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_float,
  output logic              wb_we
);

  fpu_state_t       state;
  logic [4:0]       hold_op;
  logic [4:0]       hold_rd;
  logic             hold_float;
  logic             hold_we;
  logic [LAT_W-1:0] cnt;
  logic             cnt_last;
  logic             accept;
  logic             lat_zero;
  logic             finish;
  logic             in_wait;

  // rstn gates accept so that no stall can leak out while reset is held
  assign in_wait  = (state == WAIT);
  assign lat_zero = (fpu_stall == '0);
  assign accept   = rstn && issue_valid && fpu_cont[FPU_OP_BIT] && !in_wait && !flush;
  assign finish   = in_wait && cnt_last && !flush;

  // Flush overrides the stall so the killed instruction cannot hold the pipe
  assign stall    = !flush && ((accept && !lat_zero) || in_wait);
  assign busy     = in_wait;
  assign fpu_sel  = in_wait ? hold_op : fpu_cont;

  fpu_lat_counter #(
    .LAT_W (LAT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept && !lat_zero),
    .dec      (in_wait),
    .clr      (flush),
    .load_val (fpu_stall),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // Issue FSM: latch the op on accept, leave WAIT on the last cycle or a flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      hold_op    <= '0;
      hold_rd    <= '0;
      hold_float <= 1'b0;
      hold_we    <= 1'b0;
    end else begin
      if (accept) begin
        hold_op    <= fpu_cont;
        hold_rd    <= rd_addr;
        hold_float <= rd_reg_src;
        hold_we    <= regwrite_in;
      end
      case (state)
        IDLE: if (accept && !lat_zero) state <= WAIT;
        WAIT: if (flush || cnt_last)   state <= IDLE;
        default:                       state <= IDLE;
      endcase
    end
  end

  // Writeback capture: zero-latency ops take the live inputs, others the held copy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_float <= 1'b0;
      wb_we    <= 1'b0;
    end else begin
      wb_valid <= (accept && lat_zero) || finish;
      if (accept && lat_zero) begin
        wb_data  <= fpu_y;
        wb_rd    <= rd_addr;
        wb_float <= rd_reg_src;
        wb_we    <= regwrite_in;
      end else if (finish) begin
        wb_data  <= fpu_y;
        wb_rd    <= hold_rd;
        wb_float <= hold_float;
        wb_we    <= hold_we;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: stimulus pushes expected writebacks,
// a negedge monitor pops and compares each wb_valid pulse.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int LAT_W  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              issue_valid;
  logic [4:0]        fpu_cont;
  logic [LAT_W-1:0]  fpu_stall;
  logic [4:0]        rd_addr;
  logic              rd_reg_src;
  logic              regwrite_in;
  logic              flush;
  logic [DATA_W-1:0] fpu_y;
  logic [4:0]        fpu_sel;
  logic              stall;
  logic              busy;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_rd;
  logic              wb_float;
  logic              wb_we;

  logic              y_force = 1'b0;
  logic [DATA_W-1:0] y_val   = '0;
  int                cyc     = 0;
  int                vectors = 0;
  int                miscompares = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        flt;
    logic        we;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FPU result model: a cycle-stamped pattern unless a test forces a value
  assign fpu_y = y_force ? y_val : {16'hC0DE, cyc[15:0]};

  function automatic logic [31:0] ymodel(input int c);
    logic [31:0] cv;
    cv = c;
    return {16'hC0DE, cv[15:0]};
  endfunction

  fpu_issue_ctrl #(.LAT_W(LAT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .fpu_cont(fpu_cont),
    .fpu_stall(fpu_stall), .rd_addr(rd_addr), .rd_reg_src(rd_reg_src),
    .regwrite_in(regwrite_in), .flush(flush), .fpu_y(fpu_y), .fpu_sel(fpu_sel),
    .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_float(wb_float), .wb_we(wb_we)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; fpu_cont = 5'b0; fpu_stall = '0;
    rd_addr = 5'd0; rd_reg_src = 1'b0; regwrite_in = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input int lat, input logic [4:0] rd,
                       input logic flt, input logic we);
    issue_valid = 1'b1; fpu_cont = op; fpu_stall = LAT_W'(lat);
    rd_addr = rd; rd_reg_src = flt; regwrite_in = we; flush = 1'b0;
  endtask

  task automatic expect_wb(input int c, input logic [31:0] d, input logic [4:0] rd,
                           input logic flt, input logic we);
    exp_t e;
    e.cyc = c; e.data = d; e.rd = rd; e.flt = flt; e.we = we;
    sb.push_back(e);
  endtask

  task automatic check_ctrl(input string tag, input logic s, input logic b);
    @(negedge clk);
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, s});
    chk({tag, "_busy"},  {31'b0, busy},  {31'b0, b});
  endtask

  // Monitor: every wb_valid pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rstn === 1'b1 && wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wb_unexpected: got wb_valid=1, required 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_cycle", cyc, e.cyc);
        chk("wb_data", wb_data, e.data);
        chk("wb_dest", {27'b0, wb_rd, wb_float, wb_we}, {27'b0, e.rd, e.flt, e.we});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rstn = 1'b0;
    idle();
    // Inputs active during reset must not produce stall or acceptance
    issue(OP_FDIV, 8, 5'd5, 1'b1, 1'b1);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wb", {wb_data[25:0], wb_rd, wb_float}, 32'd0);
    chk("rst_sel", {27'b0, fpu_sel}, {27'b0, OP_FDIV});
    tick();
    idle();
    rstn = 1'b1;

    // Integer op: ignored
    tick();
    issue(5'b00000, 3, 5'd6, 1'b0, 1'b1);
    check_ctrl("int", 1'b0, 1'b0);
    chk("int_sel", {27'b0, fpu_sel}, 32'd0);
    tick(); idle();
    check_ctrl("int_after", 1'b0, 1'b0);

    // fdiv L=8: stall T..T+8, wb in T+9 with fpu_y of T+8
    tick();
    t = cyc;
    issue(OP_FDIV, 8, 5'd5, 1'b1, 1'b1);
    expect_wb(t + 9, ymodel(t + 8), 5'd5, 1'b1, 1'b1);
    check_ctrl("fdiv_acc", 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(); idle();
      check_ctrl("fdiv_wait", 1'b1, 1'b1);
      chk("fdiv_sel", {27'b0, fpu_sel}, {27'b0, OP_FDIV});
    end
    tick();
    check_ctrl("fdiv_done", 1'b0, 1'b0);

    // fsgnj L=0: no stall, wb next cycle with the forced value
    tick();
    t = cyc;
    y_force = 1'b1; y_val = 32'h3F800000;
    issue(OP_FSGNJ, 0, 5'd7, 1'b1, 1'b1);
    expect_wb(t + 1, 32'h3F800000, 5'd7, 1'b1, 1'b1);
    check_ctrl("fsgnj_acc", 1'b0, 1'b0);
    tick(); idle(); y_force = 1'b0;
    check_ctrl("fsgnj_next", 1'b0, 1'b0);

    // fadd L=5 flushed in T+2: no wb, result registers untouched
    tick();
    t = cyc;
    issue(OP_FADD, 5, 5'd3, 1'b0, 1'b1);
    check_ctrl("flush_acc", 1'b1, 1'b0);
    tick(); idle();
    check_ctrl("flush_t1", 1'b1, 1'b1);
    tick(); flush = 1'b1;
    check_ctrl("flush_t2", 1'b0, 1'b1);
    tick(); flush = 1'b0;
    check_ctrl("flush_t3", 1'b0, 1'b0);
    while (cyc < t + 10) tick();
    @(negedge clk);
    chk("flush_keep", wb_data, 32'h3F800000);

    // Back-to-back fadd L=5 then fmul L=5 issued in the wb cycle
    tick();
    t = cyc;
    issue(OP_FADD, 5, 5'd1, 1'b1, 1'b1);
    expect_wb(t + 6, ymodel(t + 5), 5'd1, 1'b1, 1'b1);
    check_ctrl("b2b_acc1", 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(); idle();
      check_ctrl("b2b_wait1", 1'b1, 1'b1);
    end
    tick();
    issue(OP_FMUL, 5, 5'd2, 1'b0, 1'b1);
    expect_wb(t + 12, ymodel(t + 11), 5'd2, 1'b0, 1'b1);
    check_ctrl("b2b_acc2", 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(); idle();
      check_ctrl("b2b_wait2", 1'b1, 1'b1);
      chk("b2b_sel", {27'b0, fpu_sel}, {27'b0, OP_FMUL});
    end
    tick();
    check_ctrl("b2b_done", 1'b0, 1'b0);

    // Asynchronous reset in the middle of an fsqrt
    tick();
    issue(OP_FSQRT, 3, 5'd9, 1'b1, 1'b1);
    tick(); idle();
    tick();
    fpu_cont = 5'b01010;
    rstn = 1'b0;
    #1;
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_wbv", {31'b0, wb_valid}, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_dest", {27'b0, wb_rd, wb_float, wb_we}, 32'd0);
    chk("arst_sel", {27'b0, fpu_sel}, 32'b01010);
    tick();
    rstn = 1'b1;
    t = cyc;
    issue(OP_FCVTSW, 2, 5'd4, 1'b1, 1'b0);
    expect_wb(t + 3, ymodel(t + 2), 5'd4, 1'b1, 1'b0);
    check_ctrl("cvt_acc", 1'b1, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      tick(); idle();
      check_ctrl("cvt_wait", 1'b1, 1'b1);
    end
    tick();
    check_ctrl("cvt_done", 1'b0, 1'b0);

    repeat (3) tick();
    @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
